// File: rtl/tdm_demultiplexer_if.sv
// Bus bundle for the TDM demultiplexer: one slot-word stream in, four
// parallel channel words plus framing status out.
interface tdm_demultiplexer_if #(
  parameter int WIDTH = 1
);
  logic             in_valid;
  logic             frame_sync;
  logic [WIDTH-1:0] in;

  logic [WIDTH-1:0] out0;
  logic [WIDTH-1:0] out1;
  logic [WIDTH-1:0] out2;
  logic [WIDTH-1:0] out3;
  logic             out_valid;
  logic             locked;
  logic             sync_error;
  logic             addr0;
  logic             addr1;

  modport master (
    output in_valid,
    output frame_sync,
    output in,
    input  out0,
    input  out1,
    input  out2,
    input  out3,
    input  out_valid,
    input  locked,
    input  sync_error,
    input  addr0,
    input  addr1
  );

  modport slave (
    input  in_valid,
    input  frame_sync,
    input  in,
    output out0,
    output out1,
    output out2,
    output out3,
    output out_valid,
    output locked,
    output sync_error,
    output addr0,
    output addr1
  );
endinterface

// File: rtl/tdm_demultiplexer.sv
// 1:4 time-division demultiplexer: tracks slot position from frame_sync
// markers and presents each complete four-word frame on parallel channels.
module tdm_demultiplexer #(
  parameter int WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  tdm_demultiplexer_if.slave   bus
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic [WIDTH-1:0] shadow0_q, shadow0_d;
  logic [WIDTH-1:0] shadow1_q, shadow1_d;
  logic [WIDTH-1:0] shadow2_q, shadow2_d;
  logic [WIDTH-1:0] out0_q, out0_d;
  logic [WIDTH-1:0] out1_q, out1_d;
  logic [WIDTH-1:0] out2_q, out2_d;
  logic [WIDTH-1:0] out3_q, out3_d;
  logic             out_valid_q, out_valid_d;
  logic             sync_error_q, sync_error_d;

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    shadow0_d    = shadow0_q;
    shadow1_d    = shadow1_q;
    shadow2_d    = shadow2_q;
    out0_d       = out0_q;
    out1_d       = out1_q;
    out2_d       = out2_q;
    out3_d       = out3_q;
    out_valid_d  = 1'b0;
    sync_error_d = 1'b0;

    if (bus.in_valid) begin
      case (state_q)
        HUNT: begin
          if (bus.frame_sync) begin
            shadow0_d = bus.in;
            slot_d    = 2'd1;
            state_d   = LOCKED;
          end
        end

        LOCKED: begin
          if (bus.frame_sync) begin
            // A marker anywhere but slot 0 drops the partial frame and restarts on this beat.
            sync_error_d = (slot_q != 2'd0);
            shadow0_d    = bus.in;
            slot_d       = 2'd1;
          end else begin
            case (slot_q)
              2'd0: begin
                sync_error_d = 1'b1;
                state_d      = HUNT;
                slot_d       = 2'd0;
              end
              2'd1: begin
                shadow1_d = bus.in;
                slot_d    = 2'd2;
              end
              2'd2: begin
                shadow2_d = bus.in;
                slot_d    = 2'd3;
              end
              default: begin
                out0_d      = shadow0_q;
                out1_d      = shadow1_q;
                out2_d      = shadow2_q;
                out3_d      = bus.in;
                out_valid_d = 1'b1;
                slot_d      = 2'd0;
              end
            endcase
          end
        end

        default: begin
          state_d = HUNT;
          slot_d  = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= HUNT;
      slot_q       <= 2'd0;
      shadow0_q    <= '0;
      shadow1_q    <= '0;
      shadow2_q    <= '0;
      out0_q       <= '0;
      out1_q       <= '0;
      out2_q       <= '0;
      out3_q       <= '0;
      out_valid_q  <= 1'b0;
      sync_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      shadow0_q    <= shadow0_d;
      shadow1_q    <= shadow1_d;
      shadow2_q    <= shadow2_d;
      out0_q       <= out0_d;
      out1_q       <= out1_d;
      out2_q       <= out2_d;
      out3_q       <= out3_d;
      out_valid_q  <= out_valid_d;
      sync_error_q <= sync_error_d;
    end
  end

  assign bus.out0       = out0_q;
  assign bus.out1       = out1_q;
  assign bus.out2       = out2_q;
  assign bus.out3       = out3_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.sync_error = sync_error_q;
  assign bus.locked     = (state_q == LOCKED);
  assign bus.addr0      = slot_q[0];
  assign bus.addr1      = slot_q[1];

endmodule

// File: tb/tb_tdm_demultiplexer.sv
// Self-checking bench for tdm_demultiplexer: directed framing scenarios then
// random beats, all compared against a frame-queue reference model.
module tb_tdm_demultiplexer;

  localparam int WIDTH = 8;

  logic clk;
  logic reset_n;
  int   compared;
  int   mismatched;

  tdm_demultiplexer_if #(.WIDTH(WIDTH)) bus ();

  tdm_demultiplexer #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a frame is just the list of words captured since the marker.
  logic             m_locked;
  logic [WIDTH-1:0] m_frame[$];
  logic [WIDTH-1:0] m_out[4];
  logic             m_ov;
  logic             m_se;

  function automatic void model_reset();
    m_locked = 1'b0;
    m_frame.delete();
    for (int i = 0; i < 4; i++) m_out[i] = '0;
    m_ov = 1'b0;
    m_se = 1'b0;
  endfunction

  function automatic void model_beat(input logic v, input logic fs, input logic [WIDTH-1:0] d);
    m_ov = 1'b0;
    m_se = 1'b0;
    if (!v) return;
    if (!m_locked) begin
      if (fs) begin
        m_locked = 1'b1;
        m_frame.delete();
        m_frame.push_back(d);
      end
    end else if (fs) begin
      if (m_frame.size() != 0) m_se = 1'b1;
      m_frame.delete();
      m_frame.push_back(d);
    end else if (m_frame.size() == 0) begin
      m_se     = 1'b1;
      m_locked = 1'b0;
    end else begin
      m_frame.push_back(d);
      if (m_frame.size() == 4) begin
        for (int i = 0; i < 4; i++) m_out[i] = m_frame[i];
        m_ov = 1'b1;
        m_frame.delete();
      end
    end
  endfunction

  function automatic logic [1:0] model_addr();
    return m_locked ? 2'(m_frame.size() % 4) : 2'd0;
  endfunction

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_addr(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check_bit ({tag, ".out_valid"},  bus.out_valid,  m_ov);
    check_bit ({tag, ".sync_error"}, bus.sync_error, m_se);
    check_bit ({tag, ".locked"},     bus.locked,     m_locked);
    check_addr({tag, ".addr"},       {bus.addr1, bus.addr0}, model_addr());
    check_word({tag, ".out0"},       bus.out0,       m_out[0]);
    check_word({tag, ".out1"},       bus.out1,       m_out[1]);
    check_word({tag, ".out2"},       bus.out2,       m_out[2]);
    check_word({tag, ".out3"},       bus.out3,       m_out[3]);
  endtask

  task automatic check_frame(input string tag, input logic [WIDTH-1:0] e0, input logic [WIDTH-1:0] e1,
                             input logic [WIDTH-1:0] e2, input logic [WIDTH-1:0] e3);
    check_word({tag, ".c0"}, bus.out0, e0);
    check_word({tag, ".c1"}, bus.out1, e1);
    check_word({tag, ".c2"}, bus.out2, e2);
    check_word({tag, ".c3"}, bus.out3, e3);
  endtask

  // One cycle: drive at negedge, model advances on the edge, compare 1 time unit later.
  task automatic step(input string tag, input logic v, input logic fs, input logic [WIDTH-1:0] d);
    @(negedge clk);
    bus.in_valid   = v;
    bus.frame_sync = fs;
    bus.in         = d;
    @(posedge clk);
    model_beat(v, fs, d);
    #1;
    check_model(tag);
  endtask

  task automatic frame(input string tag, input logic [WIDTH-1:0] base);
    step(tag, 1'b1, 1'b1, base);
    step(tag, 1'b1, 1'b0, base + 8'd1);
    step(tag, 1'b1, 1'b0, base + 8'd2);
    step(tag, 1'b1, 1'b0, base + 8'd3);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset_n        = 1'b0;
    bus.in_valid   = 1'b0;
    bus.frame_sync = 1'b0;
    bus.in         = '0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check_model("reset");

    @(negedge clk);
    reset_n = 1'b1;

    // Reset then lock
    step("lock.s0", 1'b1, 1'b1, 8'h11);
    check_bit ("lock.locked_first", bus.locked, 1'b1);
    check_addr("lock.addr1", {bus.addr1, bus.addr0}, 2'd1);
    step("lock.s1", 1'b1, 1'b0, 8'h22);
    check_addr("lock.addr2", {bus.addr1, bus.addr0}, 2'd2);
    step("lock.s2", 1'b1, 1'b0, 8'h33);
    check_addr("lock.addr3", {bus.addr1, bus.addr0}, 2'd3);
    step("lock.s3", 1'b1, 1'b0, 8'h44);
    check_bit ("lock.strobe", bus.out_valid, 1'b1);
    check_frame("lock.frame", 8'h11, 8'h22, 8'h33, 8'h44);
    step("lock.idle", 1'b0, 1'b0, 8'h00);

    // Back-to-back frames with a gap inside frame two
    frame("bb.a", 8'hA0);
    check_frame("bb.a_frame", 8'hA0, 8'hA1, 8'hA2, 8'hA3);
    step("bb.b0", 1'b1, 1'b1, 8'hB0);
    step("bb.b1", 1'b1, 1'b0, 8'hB1);
    step("bb.gap", 1'b0, 1'b1, 8'hEE);
    step("bb.gap", 1'b0, 1'b0, 8'hEF);
    check_frame("bb.hold", 8'hA0, 8'hA1, 8'hA2, 8'hA3);
    step("bb.b2", 1'b1, 1'b0, 8'hB2);
    step("bb.b3", 1'b1, 1'b0, 8'hB3);
    check_frame("bb.b_frame", 8'hB0, 8'hB1, 8'hB2, 8'hB3);

    // Missing marker drops lock but keeps outputs
    step("miss", 1'b1, 1'b0, 8'h77);
    check_bit("miss.se", bus.sync_error, 1'b1);
    check_bit("miss.unlocked", bus.locked, 1'b0);
    check_frame("miss.hold", 8'hB0, 8'hB1, 8'hB2, 8'hB3);

    // HUNT discards unmarked beats, then relocks
    step("hunt.d0", 1'b1, 1'b0, 8'h55);
    step("hunt.d1", 1'b1, 1'b0, 8'h66);
    check_addr("hunt.addr", {bus.addr1, bus.addr0}, 2'd0);
    frame("hunt.f", 8'h01);
    check_frame("hunt.frame", 8'h01, 8'h02, 8'h03, 8'h04);

    // Early marker abandons the partial frame
    step("early.p0", 1'b1, 1'b1, 8'h10);
    step("early.p1", 1'b1, 1'b0, 8'h20);
    step("early.s0", 1'b1, 1'b1, 8'h30);
    check_bit("early.se", bus.sync_error, 1'b1);
    step("early.s1", 1'b1, 1'b0, 8'h40);
    step("early.s2", 1'b1, 1'b0, 8'h50);
    step("early.s3", 1'b1, 1'b0, 8'h60);
    check_frame("early.frame", 8'h30, 8'h40, 8'h50, 8'h60);

    // Asynchronous reset mid-frame
    step("mid.s0", 1'b1, 1'b1, 8'hC0);
    step("mid.s1", 1'b1, 1'b0, 8'hC1);
    step("mid.s2", 1'b1, 1'b0, 8'hC2);
    #1;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_model("mid.async");
    @(negedge clk);
    reset_n = 1'b1;
    step("mid.post0", 1'b1, 1'b0, 8'hC3);
    step("mid.post1", 1'b1, 1'b0, 8'hC4);

    // Random beats, markers fairly common so every framing rule gets exercised
    for (int i = 0; i < 400; i++) begin
      logic             v;
      logic             fs;
      logic [WIDTH-1:0] d;
      v  = ($urandom_range(3) != 0);
      fs = ($urandom_range(4) == 0);
      d  = WIDTH'($urandom_range(255));
      step("rand", v, fs, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
